layer_launch_ctrl: RTL and testbench

Launch controller directly downstream of the start-pulse generator in the MLP/conv accelerator. Consumes the one-cycle start pulse, sequences a layer as CFG_NUM_TILES tile jobs to the compute engine over a request/grant + done handshake, and reports BUSY, sticky DONE/ERR, a one-cycle IRQ and a cycle count for the AXI-lite status registers.

---
 rtl/mlp_ctrl_pkg.sv | 14 +
 rtl/layer_launch_ctrl_sat_counter.sv | 29 ++
 rtl/layer_launch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_layer_launch_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_ctrl_pkg.sv
// rtl/mlp_ctrl_pkg.sv - shared types and defaults for the layer launch controller
package mlp_ctrl_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int PERF_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT   = 2'd2,
    FINISH = 2'd3
  } launch_state_t;

endpackage

// File: rtl/layer_launch_ctrl_sat_counter.sv
// rtl/layer_launch_ctrl_sat_counter.sv - saturating up-counter with enable and synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         CLK,
  input  logic         RESETN,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] r_count;

  // clear beats enable; the count sticks at all-ones instead of wrapping
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + ONE;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/layer_launch_ctrl.sv
// rtl/layer_launch_ctrl.sv - sequences one layer as a series of tile jobs to the compute engine
module layer_launch_ctrl
  import mlp_ctrl_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int PERF_W = PERF_W_DEF
) (
  input  logic              CLK,
  input  logic              RESETN,
  input  logic              START_PULSE,
  input  logic [CNT_W-1:0]  CFG_NUM_TILES,
  input  logic              CLEAR_STATUS,
  output logic              TILE_REQ,
  output logic [CNT_W-1:0]  TILE_IDX,
  input  logic              TILE_GRANT,
  input  logic              TILE_DONE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              IRQ,
  output logic [PERF_W-1:0] PERF_CYCLES
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  launch_state_t    r_state;
  launch_state_t    w_state_nxt;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_idx;
  logic             r_tile_req;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_irq;

  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_idx_nxt;
  logic             w_tile_req_nxt;
  logic             w_busy_nxt;
  logic             w_done_nxt;
  logic             w_err_nxt;
  logic             w_irq_nxt;

  logic             w_start_ok;
  logic             w_start_run;
  logic             w_start_zero;
  logic             w_last;
  logic             w_err_evt;

  // a start is only honoured from IDLE; a zero-tile layer completes without touching the engine
  assign w_start_ok   = START_PULSE && (r_state == IDLE);
  assign w_start_run  = w_start_ok && (CFG_NUM_TILES != '0);
  assign w_start_zero = w_start_ok && (CFG_NUM_TILES == '0);
  assign w_last       = (r_idx == (r_count - ONE));
  assign w_err_evt    = (START_PULSE && r_busy)
                     || (TILE_DONE && (r_state != WAIT))
                     || (TILE_GRANT && (r_state != REQ));

  // state register
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start_run) w_state_nxt = REQ;
      REQ:     if (TILE_GRANT) w_state_nxt = WAIT;
      WAIT:    if (TILE_DONE) w_state_nxt = w_last ? FINISH : REQ;
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // next values of the registered outputs; an error event overrides a same-cycle clear
  always_comb begin
    w_count_nxt    = r_count;
    w_idx_nxt      = r_idx;
    w_tile_req_nxt = r_tile_req;
    w_busy_nxt     = r_busy;
    w_done_nxt     = r_done;
    w_err_nxt      = r_err;
    w_irq_nxt      = 1'b0;
    if (CLEAR_STATUS) begin
      w_done_nxt = 1'b0;
      w_err_nxt  = 1'b0;
    end
    case (r_state)
      IDLE: begin
        if (w_start_run) begin
          w_count_nxt    = CFG_NUM_TILES;
          w_idx_nxt      = '0;
          w_done_nxt     = 1'b0;
          w_busy_nxt     = 1'b1;
          w_tile_req_nxt = 1'b1;
        end else if (w_start_zero) begin
          w_done_nxt = 1'b1;
          w_irq_nxt  = 1'b1;
        end
      end
      REQ: begin
        if (TILE_GRANT) w_tile_req_nxt = 1'b0;
      end
      WAIT: begin
        if (TILE_DONE && !w_last) begin
          w_idx_nxt      = r_idx + ONE;
          w_tile_req_nxt = 1'b1;
        end
      end
      FINISH: begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b1;
        w_irq_nxt  = 1'b1;
      end
      default: begin
        w_tile_req_nxt = 1'b0;
      end
    endcase
    if (w_err_evt) w_err_nxt = 1'b1;
  end

  // output and datapath registers
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      r_count    <= '0;
      r_idx      <= '0;
      r_tile_req <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_count    <= w_count_nxt;
      r_idx      <= w_idx_nxt;
      r_tile_req <= w_tile_req_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_irq      <= w_irq_nxt;
    end
  end

  sat_counter #(
    .W (PERF_W)
  ) u_perf (
    .CLK     (CLK),
    .RESETN  (RESETN),
    .i_en    (r_busy),
    .i_clr   (w_start_ok),
    .o_count (PERF_CYCLES)
  );

  assign TILE_REQ = r_tile_req;
  assign TILE_IDX = r_idx;
  assign BUSY     = r_busy;
  assign DONE     = r_done;
  assign ERR      = r_err;
  assign IRQ      = r_irq;

endmodule

// File: tb/tb_layer_launch_ctrl.sv
// tb/tb_layer_launch_ctrl.sv - scoreboard bench for layer_launch_ctrl (32-bit and 4-bit perf instances)
module tb_layer_launch_ctrl;

  localparam int CNT_W = 16;

  logic             CLK = 1'b0;
  logic             RESETN = 1'b0;
  logic             START_PULSE = 1'b0;
  logic [CNT_W-1:0] CFG_NUM_TILES = '0;
  logic             CLEAR_STATUS = 1'b0;
  logic             TILE_GRANT = 1'b0;
  logic             TILE_DONE = 1'b0;

  logic             tile_req, busy, done, err, irq;
  logic [CNT_W-1:0] tile_idx;
  logic [31:0]      perf;
  logic             tile_req_4, busy_4, done_4, err_4, irq_4;
  logic [CNT_W-1:0] tile_idx_4;
  logic [3:0]       perf_4;

  typedef struct {
    logic done;
    logic busy;
    logic err;
    int   perf;
    int   perf4;
  } irq_exp_t;

  irq_exp_t irq_q[$];
  int       idx_q[$];
  int       n_tests = 0;
  int       n_fail = 0;
  logic     prev_req = 1'b0;

  layer_launch_ctrl #(.CNT_W(CNT_W), .PERF_W(32)) dut (
    .CLK(CLK), .RESETN(RESETN), .START_PULSE(START_PULSE), .CFG_NUM_TILES(CFG_NUM_TILES),
    .CLEAR_STATUS(CLEAR_STATUS), .TILE_REQ(tile_req), .TILE_IDX(tile_idx),
    .TILE_GRANT(TILE_GRANT), .TILE_DONE(TILE_DONE), .BUSY(busy), .DONE(done),
    .ERR(err), .IRQ(irq), .PERF_CYCLES(perf)
  );

  layer_launch_ctrl #(.CNT_W(CNT_W), .PERF_W(4)) dut4 (
    .CLK(CLK), .RESETN(RESETN), .START_PULSE(START_PULSE), .CFG_NUM_TILES(CFG_NUM_TILES),
    .CLEAR_STATUS(CLEAR_STATUS), .TILE_REQ(tile_req_4), .TILE_IDX(tile_idx_4),
    .TILE_GRANT(TILE_GRANT), .TILE_DONE(TILE_DONE), .BUSY(busy_4), .DONE(done_4),
    .ERR(err_4), .IRQ(irq_4), .PERF_CYCLES(perf_4)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_irq(input logic d, input logic e, input int p);
    irq_exp_t x;
    x.done  = d;
    x.busy  = 1'b0;
    x.err   = e;
    x.perf  = p;
    x.perf4 = (p > 15) ? 15 : p;
    irq_q.push_back(x);
  endtask

  // monitor: every rising TILE_REQ and every IRQ cycle consumes one scoreboard entry
  always @(negedge CLK) begin
    if (tile_req && !prev_req) begin
      if (idx_q.size() == 0) begin
        chk("tile_req_unexpected", 32'(tile_req), 32'd0);
      end else begin
        chk("tile_idx", 32'(tile_idx), 32'(idx_q[0]));
        chk("tile_idx_p4", 32'(tile_idx_4), 32'(idx_q[0]));
        chk("tile_req_p4", 32'(tile_req_4), 32'd1);
        void'(idx_q.pop_front());
      end
    end
    prev_req <= tile_req;
    if (irq) begin
      if (irq_q.size() == 0) begin
        chk("irq_unexpected", 32'(irq), 32'd0);
      end else begin
        chk("irq_done", 32'(done), 32'(irq_q[0].done));
        chk("irq_busy", 32'(busy), 32'(irq_q[0].busy));
        chk("irq_err", 32'(err), 32'(irq_q[0].err));
        chk("irq_perf", perf, 32'(irq_q[0].perf));
        chk("irq_p4", 32'(irq_4), 32'd1);
        chk("irq_done_p4", 32'(done_4), 32'(irq_q[0].done));
        chk("irq_err_p4", 32'(err_4), 32'(irq_q[0].err));
        chk("irq_busy_p4", 32'(busy_4), 32'(irq_q[0].busy));
        chk("irq_perf_p4", 32'(perf_4), 32'(irq_q[0].perf4));
        void'(irq_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, 32'(tile_req), 32'd0);
    chk({tag, "_idx"}, 32'(tile_idx), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_irq"}, 32'(irq), 32'd0);
    chk({tag, "_perf"}, perf, 32'd0);
    chk({tag, "_req_p4"}, 32'(tile_req_4), 32'd0);
    chk({tag, "_busy_p4"}, 32'(busy_4), 32'd0);
    chk({tag, "_done_p4"}, 32'(done_4), 32'd0);
    chk({tag, "_err_p4"}, 32'(err_4), 32'd0);
    chk({tag, "_perf_p4"}, 32'(perf_4), 32'd0);
  endtask

  task automatic start(input int n);
    CFG_NUM_TILES = CNT_W'(n);
    START_PULSE = 1'b1;
    tick();
    START_PULSE = 1'b0;
  endtask

  // engine model: grant after gdly cycles of REQ, then dgap idle WAIT cycles before TILE_DONE
  task automatic serve(input int eidx, input int gdly, input int dgap, input bit spur, input bit inj);
    int w = 0;
    while (!tile_req && w < 20) begin
      tick();
      w++;
    end
    if (!tile_req) begin
      chk("req_timeout", 32'(tile_req), 32'd1);
      return;
    end
    for (int i = 0; i < gdly; i++) begin
      chk("req_held", 32'(tile_req), 32'd1);
      chk("idx_held", 32'(tile_idx), 32'(eidx));
      TILE_DONE = spur && (i == 1);
      tick();
    end
    TILE_DONE = 1'b0;
    if (spur) chk("err_spurious_done", 32'(err), 32'd1);
    TILE_GRANT = 1'b1;
    if (inj) begin
      START_PULSE = 1'b1;
      CFG_NUM_TILES = 7;
    end
    tick();
    TILE_GRANT = 1'b0;
    START_PULSE = 1'b0;
    chk("req_dropped", 32'(tile_req), 32'd0);
    repeat (dgap) tick();
    TILE_DONE = 1'b1;
    tick();
    TILE_DONE = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    chk_zero("reset");
    RESETN = 1'b1;
    tick();

    // 3 tiles, 4 cycles per tile plus FINISH: 13 busy cycles
    idx_q.push_back(0); idx_q.push_back(1); idx_q.push_back(2);
    push_irq(1'b1, 1'b0, 13);
    start(3);
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int t = 0; t < 3; t++) serve(t, 0, 2, 1'b0, 1'b0);
    repeat (2) tick();
    chk("run1_irq_low", 32'(irq), 32'd0);

    // zero-tile layer: immediate DONE/IRQ, no request
    push_irq(1'b1, 1'b0, 0);
    start(0);
    chk("zero_busy", 32'(busy), 32'd0);
    chk("zero_irq", 32'(irq), 32'd1);
    tick();
    chk("zero_irq_one_cycle", 32'(irq), 32'd0);
    chk("zero_no_req", 32'(tile_req), 32'd0);

    // START during tile 1 of 4 flags ERR and is otherwise ignored
    for (int t = 0; t < 4; t++) idx_q.push_back(t);
    push_irq(1'b1, 1'b1, 9);
    start(4);
    chk("run3_done_cleared", 32'(done), 32'd0);
    for (int t = 0; t < 4; t++) serve(t, 0, 0, 1'b0, t == 1);
    tick();
    CLEAR_STATUS = 1'b1;
    tick();
    CLEAR_STATUS = 1'b0;
    chk("clear_done", 32'(done), 32'd0);
    chk("clear_err", 32'(err), 32'd0);
    tick();

    // grant held off 5 cycles with a spurious TILE_DONE in REQ
    idx_q.push_back(0); idx_q.push_back(1);
    push_irq(1'b1, 1'b1, 10);
    start(2);
    serve(0, 5, 0, 1'b1, 1'b0);
    serve(1, 0, 0, 1'b0, 1'b0);
    repeat (2) tick();
    CLEAR_STATUS = 1'b1;
    tick();
    CLEAR_STATUS = 1'b0;

    // reset in WAIT of tile 2 aborts silently; next run restarts from index 0
    idx_q.push_back(0); idx_q.push_back(1); idx_q.push_back(2);
    start(4);
    serve(0, 0, 0, 1'b0, 1'b0);
    serve(1, 0, 0, 1'b0, 1'b0);
    TILE_GRANT = 1'b1;
    tick();
    TILE_GRANT = 1'b0;
    RESETN = 1'b0;
    tick();
    chk_zero("midrun_reset");
    RESETN = 1'b1;
    tick();
    idx_q.push_back(0);
    push_irq(1'b1, 1'b0, 3);
    start(1);
    serve(0, 0, 0, 1'b0, 1'b0);
    repeat (2) tick();

    // 20-cycle run: 4-bit counter saturates at 15
    idx_q.push_back(0);
    push_irq(1'b1, 1'b0, 20);
    start(1);
    serve(0, 10, 7, 1'b0, 1'b0);
    repeat (3) tick();
    chk("perf_hold_idle", perf, 32'd20);
    chk("perf4_hold_idle", 32'(perf_4), 32'd15);

    chk("idx_queue_drained", 32'(idx_q.size()), 32'd0);
    chk("irq_queue_drained", 32'(irq_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
